// File: rtl/uart_rx_sampler.sv
// Oversampling bit sampler for a UART receiver: edge/bit counters plus mid-bit sample capture.
// Define MAJORITY_VOTE_EN to decide each bit by 2-of-3 vote around the bit centre.
module uart_rx_sampler (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       RX_IN,
  input  logic       enable,
  input  logic [5:0] Prescale,
  input  logic       PAR_EN,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       sampled_bit,
  output logic       sample_valid,
  output logic       frame_done
);

  logic [5:0] p_eff;
  logic [5:0] half;
  logic [5:0] last_edge;
  logic [3:0] last_bit;
  logic       edge_wrap;
  logic       bit_wrap;
  logic       valid_q;
  logic       done_q;

  // Anything other than 16 or 32 falls back to 8x oversampling.
  always_comb begin
    case (Prescale)
      6'd16:   p_eff = 6'd16;
      6'd32:   p_eff = 6'd32;
      default: p_eff = 6'd8;
    endcase
  end

  assign half      = {1'b0, p_eff[5:1]};
  assign last_edge = p_eff - 6'd1;
  assign last_bit  = PAR_EN ? 4'd10 : 4'd9;
  // Using >= lets a shrinking Prescale pull an out-of-range count back to 0.
  assign edge_wrap = (edge_cnt >= last_edge);
  assign bit_wrap  = (bit_cnt >= last_bit);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= 4'd0;
      done_q   <= 1'b0;
    end else if (!enable) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= 4'd0;
      done_q   <= 1'b0;
    end else begin
      edge_cnt <= edge_wrap ? 6'd0 : edge_cnt + 6'd1;
      if (edge_wrap)
        bit_cnt <= bit_wrap ? 4'd0 : bit_cnt + 4'd1;
      done_q <= edge_wrap && bit_wrap;
    end
  end

`ifdef MAJORITY_VOTE_EN
  logic vote_early;
  logic vote_mid;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      vote_early  <= 1'b1;
      vote_mid    <= 1'b1;
      sampled_bit <= 1'b1;
      valid_q     <= 1'b0;
    end else if (!enable) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= (edge_cnt == half + 6'd1);
      if (edge_cnt == half - 6'd1)
        vote_early <= RX_IN;
      if (edge_cnt == half)
        vote_mid <= RX_IN;
      // Third vote is taken live from the line on the H+1 edge.
      if (edge_cnt == half + 6'd1)
        sampled_bit <= (vote_early & vote_mid) | (vote_early & RX_IN) | (vote_mid & RX_IN);
    end
  end
`else
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sampled_bit <= 1'b1;
      valid_q     <= 1'b0;
    end else if (!enable) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= (edge_cnt == half);
      if (edge_cnt == half)
        sampled_bit <= RX_IN;
    end
  end
`endif

  // Strobes are masked so dropping enable suppresses a pending pulse in the same cycle.
  assign sample_valid = valid_q & enable;
  assign frame_done   = done_q & enable;

endmodule
